mem_stage_lsu: RTL

//  Parametrised pipeline memory stage between ALU and writeback. Passes ALU ops through in one cycle;

---
 rtl/mem_stage_lsu_if.sv | 33 +++
 rtl/mem_stage_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-cache request/response bus driven by the memory stage.
// master = LSU side, slave = cache side.
interface mem_stage_lsu_if #(
   parameter int XLEN = 64
);
   logic                cache_enable;
   logic                cache_wr_en;
   logic [XLEN-1:0]     cache_addr;
   logic [XLEN-1:0]     cache_wr_value;
   logic [XLEN/8-1:0]   cache_wr_strb;
   logic [XLEN-1:0]     cache_data;
   logic                cache_operation_complete;

   modport master (
      output cache_enable,
      output cache_wr_en,
      output cache_addr,
      output cache_wr_value,
      output cache_wr_strb,
      input  cache_data,
      input  cache_operation_complete
   );

   modport slave (
      input  cache_enable,
      input  cache_wr_en,
      input  cache_addr,
      input  cache_wr_value,
      input  cache_wr_strb,
      output cache_data,
      output cache_operation_complete
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: ALU passthrough, sized loads/stores to the
// data cache with strobes, load extension and misalignment detection.
module mem_stage_lsu #(
   parameter int XLEN  = 64,
   parameter int PC_W  = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [REG_W-1:0] in_rd,
   input  logic [XLEN-1:0]  in_store_data,
   input  logic             in_is_load,
   input  logic             in_is_store,
   input  logic [1:0]       in_size,
   input  logic             in_unsigned,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             in_is_ecall,
   input  logic             flush,
   mem_stage_lsu_if.master  cache,
   output logic             wb_valid,
   output logic [XLEN-1:0]  wb_data,
   output logic [REG_W-1:0] wb_rd,
   output logic [PC_W-1:0]  wb_pc,
   output logic             wb_is_ecall,
   output logic             wb_ld_or_alu,
   output logic             wb_misaligned
);
   localparam int SW   = XLEN / 8;
   localparam int OFFW = $clog2(SW);

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nxt;

   logic [OFFW-1:0]  off;
   logic             is_mem;
   logic             misaligned;
   logic             accept;
   logic [3:0]       sz_m1;
   logic [SW-1:0]    strb_base;

   logic [XLEN-1:0]  addr_q;
   logic [XLEN-1:0]  wdata_q;
   logic [SW-1:0]    strb_q;
   logic             wr_q;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [OFFW-1:0]  off_q;
   logic [REG_W-1:0] rd_q;
   logic [PC_W-1:0]  pc_q;
   logic             ecall_q;

   logic [XLEN-1:0]  ld_shift;
   logic [XLEN-1:0]  ld_mask;
   logic             ld_sbit;
   logic [XLEN-1:0]  ld_val;

   assign off    = in_alu_result[OFFW-1:0];
   assign is_mem = in_is_load | in_is_store;

   always_comb begin
      sz_m1     = 4'd0;
      strb_base = '0;
      unique case (in_size)
         2'd0: begin
            sz_m1     = 4'd0;
            strb_base = SW'(1);
         end
         2'd1: begin
            sz_m1     = 4'd1;
            strb_base = SW'(3);
         end
         2'd2: begin
            sz_m1     = 4'd3;
            strb_base = SW'(4'hF);
         end
         default: begin
            sz_m1     = 4'd7;
            strb_base = '1;
         end
      endcase
   end

   // doubleword is not a legal size on a 32-bit datapath
   assign misaligned = (|(4'(off) & sz_m1))
                     | ((XLEN == 32) && (in_size == 2'd3));

   assign accept = in_valid && (state == IDLE)
                 && is_mem && !misaligned;

   // load field extraction: shift lane down, mask, then extend
   assign ld_shift = cache.cache_data >> {off_q, 3'b000};

   always_comb begin
      ld_mask = '1;
      ld_sbit = ld_shift[XLEN-1];
      unique case (size_q)
         2'd0: begin
            ld_mask = XLEN'(8'hFF);
            ld_sbit = ld_shift[7];
         end
         2'd1: begin
            ld_mask = XLEN'(16'hFFFF);
            ld_sbit = ld_shift[15];
         end
         2'd2: begin
            ld_mask = XLEN'(32'hFFFF_FFFF);
            ld_sbit = ld_shift[31];
         end
         default: begin
            ld_mask = '1;
            ld_sbit = ld_shift[XLEN-1];
         end
      endcase
   end

   assign ld_val = (ld_shift & ld_mask)
                 | ({XLEN{ld_sbit & ~uns_q}} & ~ld_mask);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: if (cache.cache_operation_complete)
                  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready           = (state == IDLE);
      cache.cache_enable = (state == WAIT);
   end

   assign cache.cache_wr_en    = wr_q;
   assign cache.cache_addr     = addr_q;
   assign cache.cache_wr_value = wdata_q;
   assign cache.cache_wr_strb  = strb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q        <= '0;
         wdata_q       <= '0;
         strb_q        <= '0;
         wr_q          <= 1'b0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         off_q         <= '0;
         rd_q          <= '0;
         pc_q          <= '0;
         ecall_q       <= 1'b0;
         wb_valid      <= 1'b0;
         wb_data       <= '0;
         wb_rd         <= '0;
         wb_pc         <= '0;
         wb_is_ecall   <= 1'b0;
         wb_ld_or_alu  <= 1'b0;
         wb_misaligned <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         if (state == IDLE && in_valid) begin
            if (accept) begin
               addr_q  <= {in_alu_result[XLEN-1:OFFW],
                           OFFW'(0)};
               wdata_q <= in_store_data << {off, 3'b000};
               strb_q  <= strb_base << off;
               wr_q    <= in_is_store;
               size_q  <= in_size;
               uns_q   <= in_unsigned;
               off_q   <= off;
               rd_q    <= (flush || in_is_store) ? '0 : in_rd;
               pc_q    <= in_pc;
               ecall_q <= in_is_ecall;
            end else begin
               wb_valid      <= 1'b1;
               wb_pc         <= in_pc;
               wb_is_ecall   <= in_is_ecall;
               wb_ld_or_alu  <= is_mem;
               wb_misaligned <= is_mem;
               wb_data       <= is_mem ? '0 : in_alu_result;
               wb_rd         <= (is_mem || flush) ? '0 : in_rd;
            end
         end
         if (state == WAIT) begin
            if (flush) rd_q <= '0;
            if (cache.cache_operation_complete) begin
               wb_valid      <= 1'b1;
               wb_pc         <= pc_q;
               wb_is_ecall   <= ecall_q;
               wb_ld_or_alu  <= 1'b1;
               wb_misaligned <= 1'b0;
               wb_data       <= wr_q ? '0 : ld_val;
               wb_rd         <= (wr_q || flush) ? '0 : rd_q;
            end
         end
      end
   end
endmodule
